swap_reg_sched: RTL and testbench

- Round-robin scheduler that shares one 16-bit hold/byte-swap register between NUM_REQ requesters.
- Per operation it sequences the register's control pins: a load cycle (ce=1), then a transform cycle (ce=0, inv = requested swap).
- It waits a fixed latency, captures the register output, and returns the result with the requester ID over a valid/ready response port.
- It sits between client blocks and the shared register, and is the only block driving that register's ce/inv/data_in.

---
 rtl/swap_sched_pkg.sv | 36 +++
 rtl/swap_reg_sched_if.sv | 33 +++
 rtl/rr_arbiter.sv | 21 ++
 rtl/swap_reg_sched.sv | 120 ++++++++++++
 tb/tb_swap_reg_sched.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/swap_sched_pkg.sv
// Shared types and helpers for the swap register scheduler.
//   state_t  : scheduler FSM states
//   DW       : data width (fixed, the byte swap exchanges [15:8] and [7:0])
//   MAX_REQ  : widest requester vector rr_pick handles
//   rr_pick  : round-robin one-hot pick starting at ptr, wrapping at n
package swap_sched_pkg;

  localparam int unsigned DW      = 16;
  localparam int unsigned MAX_REQ = 8;

  typedef enum logic [2:0] {IDLE, LOAD, XFORM, WAIT, RESP} state_t;

  // Search ptr, ptr+1, ... mod n and return a one-hot of the first valid.
  // ptr < n and k < n, so a single subtraction is enough to wrap.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [2:0]         ptr,
                                                 input int unsigned        n);
    logic [MAX_REQ-1:0] grant;
    logic               found;
    int unsigned        idx;
    logic [2:0]         sel;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= n) idx = idx - n;
      sel = idx[2:0];
      if ((k < n) && !found && valid[sel]) begin
        grant[sel] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/swap_reg_sched_if.sv
// Request/response bus between client blocks and the scheduler.
//   req_valid/req_data/req_swap : per-requester request (requester i at [i*DW +: DW])
//   req_ready                   : one-hot grant
//   rsp_valid/rsp_ready         : response handshake
//   rsp_data/rsp_id             : result and owning requester index
// master = client side, slave = scheduler side.
interface swap_reg_sched_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  import swap_sched_pkg::*;

  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_swap;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DW-1:0]         rsp_data;
  logic [IDW-1:0]        rsp_id;

  modport master (
    output req_valid, req_data, req_swap, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_data, req_swap, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : request vector
//   ptr    : highest-priority index this cycle
//   enable : when low, no grant is issued
//   grant  : one-hot grant (all zero if disabled or no request)
module rr_arbiter import swap_sched_pkg::*; #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned PTRW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTRW-1:0]    ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    if (enable) grant = NUM_REQ'(rr_pick(8'(req), 3'(ptr), NUM_REQ));
  end

endmodule

// File: rtl/swap_reg_sched.sv
// Round-robin scheduler sharing one 16-bit hold/byte-swap register among
// NUM_REQ requesters. Each op: LOAD (ce=1), XFORM (inv=swap), WAIT REG_LAT
// cycles, capture reg_data_out, present it with the requester id until taken.
//   clk, rest            : clock, synchronous active-high reset
//   bus                  : request/response interface (slave side)
//   reg_ce/reg_inv       : shared register controls (registered)
//   reg_data_in          : shared register load data (registered)
//   reg_data_out         : shared register output
//   busy                 : high whenever the FSM is not in IDLE
module swap_reg_sched import swap_sched_pkg::*; #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned REG_LAT = 2,
  localparam int unsigned IDW    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rest,
  swap_reg_sched_if.slave       bus,
  output logic                  reg_ce,
  output logic                  reg_inv,
  output logic [DW-1:0]         reg_data_in,
  input  logic [DW-1:0]         reg_data_out,
  output logic                  busy
);

  state_t             state_q;
  logic [IDW-1:0]     rr_ptr_q;
  logic [IDW-1:0]     id_q;
  logic               swap_q;
  logic [3:0]         lat_cnt_q;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_id;
  logic [DW-1:0]      grant_data;
  logic               grant_swap;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req    (bus.req_valid),
    .ptr    (rr_ptr_q),
    .enable ((state_q == IDLE) && !rest),
    .grant  (grant)
  );

  assign bus.req_ready = grant;

  // Grant is one-hot, so at most one iteration matches.
  always_comb begin
    grant_id   = '0;
    grant_data = '0;
    grant_swap = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_id   = IDW'(i);
        grant_data = bus.req_data[i*DW +: DW];
        grant_swap = bus.req_swap[i];
      end
    end
  end

  // reg_data_in doubles as the latched request data; it is held until the next op.
  always_ff @(posedge clk) begin
    if (rest) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      lat_cnt_q     <= '0;
      id_q          <= '0;
      swap_q        <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_id    <= '0;
      reg_ce        <= 1'b0;
      reg_inv       <= 1'b0;
      reg_data_in   <= '0;
      busy          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|grant) begin
            state_q     <= LOAD;
            id_q        <= grant_id;
            swap_q      <= grant_swap;
            reg_data_in <= grant_data;
            reg_ce      <= 1'b1;
            busy        <= 1'b1;
          end
        end
        LOAD: begin
          state_q <= XFORM;
          reg_ce  <= 1'b0;
          reg_inv <= swap_q;
        end
        XFORM: begin
          state_q   <= WAIT;
          lat_cnt_q <= 4'(REG_LAT - 1);
        end
        WAIT: begin
          if (lat_cnt_q == 4'd0) begin
            bus.rsp_data  <= reg_data_out;
            bus.rsp_id    <= id_q;
            bus.rsp_valid <= 1'b1;
            state_q       <= RESP;
          end else begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            rr_ptr_q      <= (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + IDW'(1);
            reg_inv       <= 1'b0;
            busy          <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swap_reg_sched.sv
module tb_swap_reg_sched;
  import swap_sched_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned RL = 2;

  typedef struct {
    int          id;
    logic [15:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rest;
  always #5 clk = ~clk;

  // Main DUT (NUM_REQ=4)
  swap_reg_sched_if #(.NUM_REQ(NR)) bus ();
  logic        reg_ce, reg_inv, busy;
  logic [15:0] reg_data_in, reg_data_out;

  swap_reg_sched #(.NUM_REQ(NR), .REG_LAT(RL)) dut (
    .clk          (clk),
    .rest         (rest),
    .bus          (bus),
    .reg_ce       (reg_ce),
    .reg_inv      (reg_inv),
    .reg_data_in  (reg_data_in),
    .reg_data_out (reg_data_out),
    .busy         (busy)
  );

  // Wrap-around DUT (NUM_REQ=3); register modelled as pass-through
  swap_reg_sched_if #(.NUM_REQ(3)) bus3 ();
  logic        reg_ce3, reg_inv3, busy3;
  logic [15:0] reg_data_in3, reg_data_out3;
  assign reg_data_out3 = reg_data_in3;

  swap_reg_sched #(.NUM_REQ(3), .REG_LAT(RL)) dut3 (
    .clk          (clk),
    .rest         (rest),
    .bus          (bus3),
    .reg_ce       (reg_ce3),
    .reg_inv      (reg_inv3),
    .reg_data_in  (reg_data_in3),
    .reg_data_out (reg_data_out3),
    .busy         (busy3)
  );

  // Shared register model: loads on ce, transforms in the cycle after the
  // load, presents the result REG_LAT cycles after that cycle, 0 otherwise.
  logic        prev_ce = 1'b0;
  logic [15:0] held, mdl_val;
  int          mdl_cnt = 0;
  always @(posedge clk) begin
    prev_ce <= reg_ce;
    if (reg_ce) held <= reg_data_in;
    if (!reg_ce && prev_ce) begin
      mdl_val <= reg_inv ? {held[7:0], held[15:8]} : held;
      mdl_cnt <= RL;
    end else if (mdl_cnt > 0) begin
      mdl_cnt <= mdl_cnt - 1;
    end
  end
  assign reg_data_out = (mdl_cnt == 1) ? mdl_val : 16'h0000;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_chk = 0;
  int   n_err = 0;
  int   acc_cnt = 0;
  bit   gap_chk = 1'b0;
  rsp_t rsp_q[$];
  int   gnt_q[$];
  logic [15:0] tbl_data [NR];
  logic        tbl_swap [NR];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_msg(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: event did not match expectation (cycle %0d)", name, cyc);
  endtask

  task automatic set_req(input int i, input logic [15:0] d, input logic s);
    tbl_data[i] = d;
    tbl_swap[i] = s;
    bus.req_data[i*16 +: 16] = d;
    bus.req_swap[i] = s;
  endtask

  task automatic push_rsp(input int id, input logic [15:0] d);
    rsp_t e;
    e.id   = id;
    e.data = d;
    rsp_q.push_back(e);
  endtask

  task automatic wait_acc(input int n);
    int start = acc_cnt;
    int t = 0;
    while (acc_cnt < start + n && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (acc_cnt < start + n) fail_msg("accept_timeout");
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((rsp_q.size() != 0 || gnt_q.size() != 0 || busy) && t < 200);
    if (t >= 200) fail_msg("idle_timeout");
  endtask

  // Monitor / scoreboard
  initial begin
    int          ph = 0;
    bit          active = 1'b0;
    int          cur = 0;
    bit          stall = 1'b0;
    logic [15:0] pd = '0;
    logic [1:0]  pid = '0;
    int          hs_cyc = 0;
    bit          hs_seen = 1'b0;
    rsp_t        e;
    int          g;
    forever begin
      @(negedge clk);
      if (rest) begin
        active = 1'b0;
        stall  = 1'b0;
        continue;
      end
      if (active) begin
        ph++;
        if (ph == 1) begin
          chk("load_ce", reg_ce, 1);
          chk("load_inv", reg_inv, 0);
          chk("load_data", reg_data_in, tbl_data[cur]);
          chk("load_busy", busy, 1);
        end else if (ph == 2) begin
          chk("xform_ce", reg_ce, 0);
          chk("xform_inv", reg_inv, tbl_swap[cur]);
          chk("xform_data", reg_data_in, tbl_data[cur]);
        end else if (ph <= RL + 2) begin
          chk("wait_ce", reg_ce, 0);
          chk("wait_inv", reg_inv, tbl_swap[cur]);
          chk("wait_rsp_valid", bus.rsp_valid, 0);
        end else if (ph == RL + 3) begin
          chk("rsp_latency", bus.rsp_valid, 1);
        end
      end
      if (bus.rsp_valid && !bus.rsp_ready) begin
        chk("stall_req_ready", bus.req_ready, 0);
        chk("stall_busy", busy, 1);
        if (stall) begin
          chk("stall_data", bus.rsp_data, pd);
          chk("stall_id", bus.rsp_id, pid);
        end
        stall = 1'b1;
        pd    = bus.rsp_data;
        pid   = bus.rsp_id;
      end else begin
        stall = 1'b0;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (rsp_q.size() == 0) begin
          fail_msg("unexpected_rsp");
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_data", bus.rsp_data, e.data);
          chk("rsp_id", bus.rsp_id, e.id);
        end
        active  = 1'b0;
        hs_cyc  = cyc;
        hs_seen = 1'b1;
      end
      if (|(bus.req_valid & bus.req_ready)) begin
        if (gnt_q.size() == 0) begin
          fail_msg("unexpected_grant");
        end else begin
          g = gnt_q.pop_front();
          chk("grant_onehot", bus.req_ready, 4'b0001 << g);
          cur = g;
        end
        if (gap_chk && hs_seen) chk("grant_gap", cyc - hs_cyc, 1);
        active = 1'b1;
        ph     = 0;
        acc_cnt++;
      end
    end
  end

  // Stimulus
  initial begin
    int t;
    for (int i = 0; i < int'(NR); i++) begin
      tbl_data[i] = '0;
      tbl_swap[i] = 1'b0;
    end
    rest           = 1'b1;
    bus.req_valid  = 4'b1111;
    bus.req_data   = '0;
    bus.req_swap   = '0;
    bus.rsp_ready  = 1'b1;
    bus3.req_valid = '0;
    bus3.req_data  = {16'h3333, 16'h2222, 16'h1111};
    bus3.req_swap  = '0;
    bus3.rsp_ready = 1'b1;

    // Reset state, with requests pending to show reset blocks grants
    @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_reg_ce", reg_ce, 0);
    chk("rst_reg_inv", reg_inv, 0);
    chk("rst_reg_data_in", reg_data_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    @(posedge clk);
    #1 rest = 1'b0;
    bus.req_valid = '0;

    // Single op with swap: requester 2
    set_req(2, 16'h12AB, 1'b1);
    gnt_q.push_back(2);
    push_rsp(2, 16'hAB12);
    bus.req_valid = 4'b0100;
    wait_acc(1);
    @(posedge clk);
    #1 bus.req_valid = '0;
    wait_idle();

    // Pass-through: requester 0
    @(posedge clk);
    #1 set_req(0, 16'hBEEF, 1'b0);
    gnt_q.push_back(0);
    push_rsp(0, 16'hBEEF);
    bus.req_valid = 4'b0001;
    wait_acc(1);
    @(posedge clk);
    #1 bus.req_valid = '0;
    wait_idle();

    // Fairness from reset: all four valid
    @(posedge clk);
    #1 rest = 1'b1;
    @(posedge clk);
    #1 rest = 1'b0;
    set_req(0, 16'h0102, 1'b1);
    set_req(1, 16'h3344, 1'b0);
    set_req(2, 16'hA5C3, 1'b1);
    set_req(3, 16'hF00D, 1'b1);
    gnt_q.push_back(0); push_rsp(0, 16'h0201);
    gnt_q.push_back(1); push_rsp(1, 16'h3344);
    gnt_q.push_back(2); push_rsp(2, 16'hC3A5);
    gnt_q.push_back(3); push_rsp(3, 16'h0DF0);
    gnt_q.push_back(0); push_rsp(0, 16'h0201);
    bus.req_valid = 4'b1111;
    wait_acc(5);
    @(posedge clk);
    #1 bus.req_valid = '0;
    wait_idle();

    // Backpressure: rr_ptr=1, requesters 1 and 2 valid
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    gnt_q.push_back(1); push_rsp(1, 16'h3344);
    gnt_q.push_back(2); push_rsp(2, 16'hC3A5);
    bus.req_valid = 4'b0110;
    wait_acc(1);
    @(posedge clk);
    #1 bus.req_valid = 4'b0100;
    gap_chk = 1'b1;
    t = 0;
    while (!bus.rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.rsp_valid) fail_msg("bp_rsp_timeout");
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    wait_acc(1);
    @(posedge clk);
    #1 bus.req_valid = '0;
    gap_chk = 1'b0;
    wait_idle();

    // Reset during WAIT: requester 3's op is dropped
    @(posedge clk);
    #1 gnt_q.push_back(3);
    bus.req_valid = 4'b1000;
    wait_acc(1);
    @(posedge clk);
    #1 bus.req_valid = '0;
    t = 0;
    while (!reg_inv && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!reg_inv) fail_msg("xform_timeout");
    @(posedge clk);
    #1 rest = 1'b1;
    @(posedge clk);
    #1 rest = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_reg_ce", reg_ce, 0);
    chk("midrst_reg_inv", reg_inv, 0);
    // rr_ptr back at 0: with 1 and 3 valid, 1 wins, then 3
    @(posedge clk);
    #1 gnt_q.push_back(1); push_rsp(1, 16'h3344);
    gnt_q.push_back(3); push_rsp(3, 16'h0DF0);
    bus.req_valid = 4'b1010;
    wait_acc(2);
    @(posedge clk);
    #1 bus.req_valid = '0;
    wait_idle();

    // Wrap-around on the 3-requester instance
    @(posedge clk);
    #1 bus3.req_valid = 3'b100;
    @(negedge clk);
    chk("wrap_first_grant", bus3.req_ready, 3'b100);
    @(posedge clk);
    #1 bus3.req_valid = 3'b101;
    t = 0;
    while (!bus3.rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("wrap_rsp_id_a", bus3.rsp_id, 2);
    chk("wrap_rsp_data_a", bus3.rsp_data, 16'h3333);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus3.req_ready == 3'b000 && t < 50);
    chk("wrap_second_grant", bus3.req_ready, 3'b001);
    @(posedge clk);
    #1 bus3.req_valid = '0;
    t = 0;
    while (!bus3.rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("wrap_rsp_id_b", bus3.rsp_id, 0);
    chk("wrap_rsp_data_b", bus3.rsp_data, 16'h1111);

    repeat (10) @(negedge clk);
    chk("rsp_queue_drained", rsp_q.size(), 0);
    chk("gnt_queue_drained", gnt_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
